// File: rtl/control_pkg.sv
// Shared encodings for the microprogram sequencer: sequencing opcodes,
// sequencer states and default sizing.
package control_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 5;
  localparam int DEFAULT_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    SEQ_INC      = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_JUMP_IF  = 3'd2,
    SEQ_CALL     = 3'd3,
    SEQ_RET      = 3'd4,
    SEQ_DISPATCH = 3'd5,
    SEQ_HALT     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    DECODE = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/micro_return_stack.sv
// LIFO of return addresses for microcode CALL/RET. The caller is expected to
// gate push with full and pop with empty; illegal requests are dropped here.
module micro_return_stack
  import control_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_STACK_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [SP_W-1:0]       sp_r;
  logic [PTR_W-1:0]      top_idx_s;

  // sp wraps cleanly in the low bits, so sp-1 always indexes the top entry
  assign top_idx_s = sp_r[PTR_W-1:0] - PTR_W'(1);
  assign pop_data  = mem_r[top_idx_s];
  assign full      = (sp_r == SP_W'(DEPTH));
  assign empty     = (sp_r == SP_W'(0));

  // Stack pointer and storage update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !full) begin
      mem_r[sp_r[PTR_W-1:0]] <= push_data;
      sp_r                   <= sp_r + SP_W'(1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - SP_W'(1);
    end
  end

endmodule

// File: rtl/control_store_sequencer.sv
// Microprogram sequencer: owns the micro-PC, strobes control-store reads,
// loads the instruction register and picks the next micro-address.
module control_store_sequencer
  import control_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] cs_address,
  output logic                  cs_read_enable,
  input  logic                  cs_data_valid,
  output logic                  ir_load,
  input  logic [2:0]            seq_op,
  input  logic [ADDR_WIDTH-1:0] next_address,
  input  logic                  condition,
  input  logic [ADDR_WIDTH-1:0] dispatch_address,
  input  logic                  resume,
  output logic                  halted,
  output logic                  stack_error
);

  state_e                state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] upc_r, upc_next_s, upc_inc_s;
  logic                  stack_error_r, err_set_s;
  logic                  push_s, pop_s, full_s, empty_s;
  logic [ADDR_WIDTH-1:0] pop_data_s;

  assign upc_inc_s = upc_r + ADDR_WIDTH'(1);

  micro_return_stack #(
    .DATA_WIDTH(ADDR_WIDTH),
    .DEPTH     (STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(upc_inc_s),
    .pop_data (pop_data_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Next-state and next-upc selection
  always_comb begin
    state_next_s = state_r;
    upc_next_s   = upc_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      FETCH: state_next_s = WAIT;
      WAIT: begin
        if (cs_data_valid) begin
          state_next_s = DECODE;
        end else begin
          state_next_s = WAIT;
        end
      end
      DECODE: begin
        state_next_s = FETCH;
        case (seq_op_e'(seq_op))
          SEQ_JUMP: upc_next_s = next_address;
          SEQ_JUMP_IF: begin
            if (condition) begin
              upc_next_s = next_address;
            end else begin
              upc_next_s = upc_inc_s;
            end
          end
          SEQ_CALL: begin
            if (full_s) begin
              err_set_s    = 1'b1;
              state_next_s = HALTED;
            end else begin
              push_s     = 1'b1;
              upc_next_s = next_address;
            end
          end
          SEQ_RET: begin
            if (empty_s) begin
              err_set_s    = 1'b1;
              state_next_s = HALTED;
            end else begin
              pop_s      = 1'b1;
              upc_next_s = pop_data_s;
            end
          end
          SEQ_DISPATCH: upc_next_s = dispatch_address;
          SEQ_HALT: begin
            upc_next_s   = upc_inc_s;
            state_next_s = HALTED;
          end
          default: upc_next_s = upc_inc_s;
        endcase
      end
      HALTED: begin
        if (resume && !stack_error_r) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = HALTED;
        end
      end
      default: state_next_s = FETCH;
    endcase
  end

  // State, micro-PC and sticky error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= FETCH;
      upc_r         <= '0;
      stack_error_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == DECODE) begin
        upc_r <= upc_next_s;
      end
      if (err_set_s) begin
        stack_error_r <= 1'b1;
      end
    end
  end

  // Reset resets state to FETCH, so the read strobe is masked while it is held
  assign cs_read_enable = (state_r == FETCH) && !reset;
  assign ir_load        = (state_r == WAIT) && cs_data_valid;
  assign halted         = (state_r == HALTED);
  assign cs_address     = upc_r;
  assign stack_error    = stack_error_r;

endmodule
